// File: rtl/sdram_emu.sv
// SDR SDRAM chip-side emulator: decodes controller commands, serves reads/writes
// from an on-chip byte-split store and flags protocol violations.
module sdram_emu #(
   parameter int MEM_AW = 12
) (
   input  logic        clk,
   input  logic        init,
   input  logic        sd_cs,
   input  logic        sd_ras,
   input  logic        sd_cas,
   input  logic        sd_we,
   input  logic [1:0]  sd_ba,
   input  logic [11:0] sd_addr,
   input  logic [1:0]  sd_dqm,
   input  logic [15:0] sd_din,
   output logic [15:0] sd_dout,
   output logic        sd_doe,
   output logic        ready,
   output logic        err,
   output logic [15:0] refresh_cnt
);
   localparam logic [2:0] OP_LOAD_MODE = 3'b000;
   localparam logic [2:0] OP_REFRESH   = 3'b001;
   localparam logic [2:0] OP_PRECHARGE = 3'b010;
   localparam logic [2:0] OP_ACTIVE    = 3'b011;
   localparam logic [2:0] OP_WRITE     = 3'b100;
   localparam logic [2:0] OP_READ      = 3'b101;

   logic [3:0]       open_q, open_d;
   logic [3:0][11:0] row_q, row_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;
   logic [2:0]       cl_q, cl_d;
   logic [15:0]      refresh_q, refresh_d;
   logic             st0_vld_q, st0_vld_d, st1_vld_q, st1_vld_d;
   logic [1:0]       st0_dqm_q, st0_dqm_d, st1_dqm_q, st1_dqm_d;
   logic             doe_q, doe_d;
   logic [15:0]      dout_q, dout_d;
   logic [15:0]      st0_word_q, st1_word_q;

   logic [21:0]       word_addr;
   logic [MEM_AW-1:0] mem_idx;
   logic              wr_en, rd_en, bank_ok, mode_ok;
   logic              sel_vld;
   logic [1:0]        sel_dqm;
   logic [15:0]       sel_word;

   // Byte-split store so each half honours its own dqm bit on writes
   logic [7:0] mem_lo [0:(1<<MEM_AW)-1];
   logic [7:0] mem_hi [0:(1<<MEM_AW)-1];

   always_comb begin
      word_addr = {sd_ba, row_q[sd_ba], sd_addr[7:0]};
      mem_idx   = MEM_AW'(word_addr);
      bank_ok   = ready_q && open_q[sd_ba];
      mode_ok   = (sd_addr[6:4] == 3'd2 || sd_addr[6:4] == 3'd3) && (sd_addr[2:0] == 3'b000);

      open_d    = open_q;
      row_d     = row_q;
      ready_d   = ready_q;
      err_d     = err_q;
      cl_d      = cl_q;
      refresh_d = refresh_q;
      wr_en     = 1'b0;
      rd_en     = 1'b0;

      if (!init && !sd_cs) begin
         case ({sd_ras, sd_cas, sd_we})
            OP_ACTIVE: begin
               if (!ready_q || open_q[sd_ba]) err_d = 1'b1;
               open_d[sd_ba] = 1'b1;
               row_d[sd_ba]  = sd_addr;
            end
            OP_READ, OP_WRITE: begin
               if (!bank_ok) begin
                  err_d = 1'b1;
               end else begin
                  rd_en = sd_we;
                  wr_en = !sd_we;
                  if (sd_addr[10]) open_d[sd_ba] = 1'b0;
               end
            end
            OP_PRECHARGE: begin
               if (sd_addr[10]) open_d = 4'b0000;
               else open_d[sd_ba] = 1'b0;
            end
            OP_REFRESH: begin
               if (|open_q) err_d = 1'b1;
               refresh_d = refresh_q + 16'd1;
            end
            OP_LOAD_MODE: begin
               if (|open_q) err_d = 1'b1;
               if (mode_ok) begin
                  cl_d    = sd_addr[6:4];
                  ready_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // Stage 0 holds the store read from the command edge; stage 1 adds a cycle for CL=3
      st0_vld_d = rd_en;
      st0_dqm_d = sd_dqm;
      st1_vld_d = st0_vld_q;
      st1_dqm_d = st0_dqm_q;
      sel_vld   = (cl_q == 3'd3) ? st1_vld_q  : st0_vld_q;
      sel_dqm   = (cl_q == 3'd3) ? st1_dqm_q  : st0_dqm_q;
      sel_word  = (cl_q == 3'd3) ? st1_word_q : st0_word_q;
      doe_d     = sel_vld;
      dout_d    = sel_vld ? {sel_dqm[1] ? 8'h00 : sel_word[15:8],
                             sel_dqm[0] ? 8'h00 : sel_word[7:0]} : 16'h0000;
   end

   always_ff @(posedge clk) begin
      if (init) begin
         open_q    <= 4'b0000;
         row_q     <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         cl_q      <= 3'd2;
         refresh_q <= 16'h0000;
         st0_vld_q <= 1'b0;
         st0_dqm_q <= 2'b00;
         st1_vld_q <= 1'b0;
         st1_dqm_q <= 2'b00;
         doe_q     <= 1'b0;
         dout_q    <= 16'h0000;
      end else begin
         open_q    <= open_d;
         row_q     <= row_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         cl_q      <= cl_d;
         refresh_q <= refresh_d;
         st0_vld_q <= st0_vld_d;
         st0_dqm_q <= st0_dqm_d;
         st1_vld_q <= st1_vld_d;
         st1_dqm_q <= st1_dqm_d;
         doe_q     <= doe_d;
         dout_q    <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !sd_dqm[0]) mem_lo[mem_idx] <= sd_din[7:0];
      if (wr_en && !sd_dqm[1]) mem_hi[mem_idx] <= sd_din[15:8];
      st0_word_q <= {mem_hi[mem_idx], mem_lo[mem_idx]};
      st1_word_q <= st0_word_q;
   end

   assign sd_dout     = dout_q;
   assign sd_doe      = doe_q;
   assign ready       = ready_q;
   assign err         = err_q;
   assign refresh_cnt = refresh_q;
endmodule

// File: tb/tb_sdram_emu.sv
// Directed bench for sdram_emu: read results go through a scoreboard queue
// tagged with the cycle they must appear on; every idle cycle expects sd_doe=0.
module tb_sdram_emu;
   logic        clk = 1'b0;
   logic        init = 1'b0;
   logic        sd_cs = 1'b0, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
   logic [1:0]  sd_ba = 2'b00;
   logic [11:0] sd_addr = 12'h000;
   logic [1:0]  sd_dqm = 2'b00;
   logic [15:0] sd_din = 16'h0000;
   logic [15:0] sd_dout;
   logic        sd_doe;
   logic        ready;
   logic        err;
   logic [15:0] refresh_cnt;

   localparam logic [3:0] C_NOP  = 4'b0111;
   localparam logic [3:0] C_ACT  = 4'b0011;
   localparam logic [3:0] C_RD   = 4'b0101;
   localparam logic [3:0] C_WR   = 4'b0100;
   localparam logic [3:0] C_PRE  = 4'b0010;
   localparam logic [3:0] C_REF  = 4'b0001;
   localparam logic [3:0] C_LMR  = 4'b0000;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t sb[$];
   exp_t e_m;
   int   cyc = 0;
   int   cl_m = 2;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   bit   mon_en = 1'b0;

   sdram_emu #(.MEM_AW(12)) dut (
      .clk(clk), .init(init),
      .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas), .sd_we(sd_we),
      .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_dqm(sd_dqm), .sd_din(sd_din),
      .sd_dout(sd_dout), .sd_doe(sd_doe), .ready(ready), .err(err),
      .refresh_cnt(refresh_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Read data must appear exactly on its due cycle; any other cycle must be idle
   always @(negedge clk) begin
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e_m = sb.pop_front();
            check("rd_doe", {31'b0, sd_doe}, 32'd1);
            check("rd_data", {16'b0, sd_dout}, {16'b0, e_m.data});
            $display("read return cycle %0d data %h expected %h", cyc, sd_dout, e_m.data);
         end else begin
            check("idle_doe", {31'b0, sd_doe}, 32'd0);
         end
      end
   end

   task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [11:0] a,
                        input logic [15:0] d, input logic [1:0] m);
      {sd_cs, sd_ras, sd_cas, sd_we} = c;
      sd_ba = ba; sd_addr = a; sd_din = d; sd_dqm = m;
      @(posedge clk); #1;
      {sd_cs, sd_ras, sd_cas, sd_we} = C_NOP;
      $display("cmd %b ba %0d addr %h din %h dqm %b at cycle %0d", c, ba, a, d, m, cyc);
   endtask

   task automatic rd(input logic [1:0] ba, input logic [11:0] a, input logic [1:0] m,
                     input logic [15:0] exp);
      exp_t e;
      issue(C_RD, ba, a, 16'h0000, m);
      e.data = exp;
      e.due  = cyc + cl_m - 1;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic init_pulse();
      init = 1'b1;
      idle(2);
      init = 1'b0;
      $display("init pulse done at cycle %0d", cyc);
   endtask

   task automatic bring_up();
      issue(C_PRE, 2'd0, 12'h400, 16'h0, 2'b00);
      issue(C_LMR, 2'd0, 12'h220, 16'h0, 2'b00);
      cl_m = 2;
   endtask

   initial begin
      init_pulse();
      mon_en = 1'b1;
      check("reset_ready", {31'b0, ready}, 32'd0);
      check("reset_err", {31'b0, err}, 32'd0);
      check("reset_refresh", {16'b0, refresh_cnt}, 32'd0);
      check("reset_doe", {31'b0, sd_doe}, 32'd0);

      bring_up();
      check("init_ready", {31'b0, ready}, 32'd1);
      check("init_err", {31'b0, err}, 32'd0);

      // Write/read with auto-precharge, bank 1 row 5
      issue(C_ACT, 2'd1, 12'h005, 16'h0, 2'b00);
      issue(C_WR,  2'd1, 12'h43C, 16'hBEEF, 2'b00);
      issue(C_ACT, 2'd1, 12'h005, 16'h0, 2'b00);
      rd(2'd1, 12'h43C, 2'b00, 16'hBEEF);
      idle(3);
      check("wr_rd_err", {31'b0, err}, 32'd0);

      // Byte masks, write-then-read, write during in-flight read
      issue(C_ACT, 2'd0, 12'h012, 16'h0, 2'b00);
      issue(C_WR,  2'd0, 12'h010, 16'h1234, 2'b00);
      issue(C_WR,  2'd0, 12'h010, 16'hABCD, 2'b10);
      rd(2'd0, 12'h010, 2'b00, 16'h12CD);
      rd(2'd0, 12'h010, 2'b01, 16'h1200);
      issue(C_WR,  2'd0, 12'h011, 16'h5555, 2'b00);
      rd(2'd0, 12'h011, 2'b00, 16'h5555);
      issue(C_WR,  2'd0, 12'h011, 16'h6666, 2'b00);
      rd(2'd0, 12'h011, 2'b00, 16'h6666);
      idle(4);
      issue(C_PRE, 2'd0, 12'h400, 16'h0, 2'b00);

      // CL=3 with back-to-back reads
      issue(C_LMR, 2'd0, 12'h230, 16'h0, 2'b00);
      cl_m = 3;
      check("cl3_ready", {31'b0, ready}, 32'd1);
      issue(C_ACT, 2'd2, 12'h007, 16'h0, 2'b00);
      issue(C_WR,  2'd2, 12'h001, 16'h0F0F, 2'b00);
      rd(2'd2, 12'h001, 2'b00, 16'h0F0F);
      rd(2'd2, 12'h001, 2'b10, 16'h000F);
      idle(5);
      issue(C_PRE, 2'd0, 12'h400, 16'h0, 2'b00);
      issue(C_LMR, 2'd0, 12'h220, 16'h0, 2'b00);
      cl_m = 2;
      check("cl3_err", {31'b0, err}, 32'd0);

      // Read to closed bank: error, no data
      issue(C_RD, 2'd1, 12'h03C, 16'h0, 2'b00);
      check("closed_rd_err", {31'b0, err}, 32'd1);
      idle(4);
      init_pulse();
      check("err_cleared", {31'b0, err}, 32'd0);
      check("ready_cleared", {31'b0, ready}, 32'd0);

      // Refresh with a bank open
      bring_up();
      issue(C_ACT, 2'd2, 12'h007, 16'h0, 2'b00);
      issue(C_REF, 2'd0, 12'h000, 16'h0, 2'b00);
      check("ref_open_err", {31'b0, err}, 32'd1);

      init_pulse();
      bring_up();
      for (int i = 0; i < 3; i++) issue(C_REF, 2'd0, 12'h000, 16'h0, 2'b00);
      check("refresh_cnt3", {16'b0, refresh_cnt}, 32'd3);
      check("refresh_err", {31'b0, err}, 32'd0);

      // init one cycle after a READ: no data may ever appear
      issue(C_ACT, 2'd0, 12'h012, 16'h0, 2'b00);
      issue(C_RD,  2'd0, 12'h010, 16'h0, 2'b00);
      init_pulse();
      idle(4);
      check("midrd_refresh", {16'b0, refresh_cnt}, 32'd0);
      check("midrd_doe", {31'b0, sd_doe}, 32'd0);

      // Store survives init
      bring_up();
      issue(C_ACT, 2'd0, 12'h012, 16'h0, 2'b00);
      rd(2'd0, 12'h010, 2'b00, 16'h12CD);
      idle(3);
      issue(C_PRE, 2'd0, 12'h400, 16'h0, 2'b00);

      // Illegal mode value (CL=4)
      init_pulse();
      issue(C_PRE, 2'd0, 12'h400, 16'h0, 2'b00);
      issue(C_LMR, 2'd0, 12'h240, 16'h0, 2'b00);
      check("badmode_err", {31'b0, err}, 32'd1);
      check("badmode_ready", {31'b0, ready}, 32'd0);

      idle(4);
      check("sb_drained", sb.size(), 32'd0);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
